// File: rtl/dcm_multi_controller.sv
// Decodes in-band clock commands from malformed work packets and serially programs NUM_DCM DCM_CLKGEN channels.
// Define DCM_TIMEOUT_EN to enable the PROGDONE timeout and sticky err flag; otherwise WAIT_DONE waits forever and err is 0.
module dcm_multi_controller #(
   parameter int NUM_DCM      = 2,
   parameter int INIT_MULT    = 16,
   parameter int MIN_MULT     = 2,
   parameter int MAX_MULT     = 64,
   parameter int DIVIDER      = 8,
   parameter int DONE_TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [255:0]         midstate,
   input  logic [255:0]         data2,
   input  logic                 start,
   output logic [NUM_DCM-1:0]   dcm_prog_en,
   output logic [NUM_DCM-1:0]   dcm_prog_data,
   input  logic [NUM_DCM-1:0]   dcm_prog_done,
   output logic                 busy,
   output logic [8*NUM_DCM-1:0] cur_mult,
   output logic                 err
);
   localparam int SW = (NUM_DCM > 1) ? $clog2(NUM_DCM) : 1;
   localparam logic [7:0] MIN_M  = 8'(MIN_MULT);
   localparam logic [7:0] MAX_M  = 8'(MAX_MULT);
   localparam logic [7:0] INIT_M = (INIT_MULT < MIN_MULT) ? MIN_M :
                                   (INIT_MULT > MAX_MULT) ? MAX_M : 8'(INIT_MULT);
   localparam logic [7:0] D_M1   = 8'(DIVIDER - 1);

   typedef enum logic [2:0] {IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [SW-1:0]           sel_q, sel_d, pick;
   logic [7:0]              m_q, m_d, m_m1;
   logic [NUM_DCM-1:0]      pend_q, pend_d;
   logic [NUM_DCM-1:0][7:0] req_q, req_d, cur_q, cur_d;
   logic [7:0]              c_id, c_arg_raw, c_chan, c_chk, c_arg;
   logic                    cmd_vld, en_bit, dat_bit;
   logic                    unused_data2;
`ifdef DCM_TIMEOUT_EN
   logic [9:0]              tmo_q, tmo_d;
   logic                    err_q, err_d;
`endif

   function automatic logic [7:0] clamp(input logic [7:0] x);
      if (x < MIN_M) return MIN_M;
      if (x > MAX_M) return MAX_M;
      return x;
   endfunction

   assign c_id      = data2[71:64];
   assign c_arg_raw = data2[79:72];
   assign c_chan    = data2[87:80];
   assign c_chk     = data2[95:88];
   assign c_arg     = clamp(c_arg_raw);
   assign cmd_vld   = start && (data2[63:32] == 32'hFFFF_FFFF) && (midstate == '0) &&
                      (c_chk == (c_id ^ c_arg_raw ^ c_chan ^ 8'hA5));
   assign unused_data2 = ^{data2[255:96], data2[31:0]};
   assign m_m1      = m_q - 8'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      m_d     = m_q;
      pend_d  = pend_q;
      req_d   = req_q;
      cur_d   = cur_q;
      en_bit  = 1'b0;
      dat_bit = 1'b0;
      pick    = '0;
`ifdef DCM_TIMEOUT_EN
      tmo_d   = tmo_q;
      err_d   = err_q;
`endif
      for (int i = NUM_DCM - 1; i >= 0; i--)
         if (pend_q[i]) pick = SW'(i);

      case (state_q)
         IDLE: if (|pend_q) begin
            state_d      = LOAD_D;
            cnt_d        = '0;
            sel_d        = pick;
            m_d          = req_q[pick];
            pend_d[pick] = 1'b0;
         end
         LOAD_D: begin
            en_bit  = 1'b1;
            dat_bit = (cnt_q == 4'd0) ? 1'b1 : (cnt_q == 4'd1) ? 1'b0 : D_M1[3'(cnt_q - 4'd2)];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin state_d = GAP1; cnt_d = '0; end
         end
         GAP1: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd1) begin state_d = LOAD_M; cnt_d = '0; end
         end
         LOAD_M: begin
            en_bit  = 1'b1;
            dat_bit = (cnt_q < 4'd2) ? 1'b1 : m_m1[3'(cnt_q - 4'd2)];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin state_d = GAP2; cnt_d = '0; end
         end
         GAP2: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd1) begin state_d = GO; cnt_d = '0; end
         end
         GO: begin
            en_bit  = 1'b1;
            state_d = WAIT_DONE;
`ifdef DCM_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         WAIT_DONE: begin
            if (dcm_prog_done[sel_q]) begin
               cur_d[sel_q] = m_q;
               state_d      = IDLE;
            end
`ifdef DCM_TIMEOUT_EN
            else if (tmo_q == 10'(DONE_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 10'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      // Commands apply after arbitration so a request arriving during launch or mid-frame re-arms the channel.
      if (cmd_vld) begin
         for (int i = 0; i < NUM_DCM; i++) begin
            if ((c_id == 8'd0 && 32'(c_chan) == i) || c_id == 8'd1) begin
               req_d[i] = c_arg;
               if (c_arg != cur_d[i] || (state_d != IDLE && 32'(sel_d) == i && c_arg != m_d))
                  pend_d[i] = 1'b1;
            end
            if (c_id == 8'd2 && 32'(c_chan) == i) pend_d[i] = 1'b1;
         end
`ifdef DCM_TIMEOUT_EN
         if (c_id == 8'd3) err_d = 1'b0;
`endif
      end
   end

   always_comb begin
      dcm_prog_en   = '0;
      dcm_prog_data = '0;
      for (int i = 0; i < NUM_DCM; i++) begin
         dcm_prog_en[i]   = en_bit && (32'(sel_q) == i);
         dcm_prog_data[i] = dat_bit && (32'(sel_q) == i);
      end
   end

   assign busy     = (state_q != IDLE);
   assign cur_mult = cur_q;
`ifdef DCM_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         m_q     <= '0;
         pend_q  <= '1;
         req_q   <= {NUM_DCM{INIT_M}};
         cur_q   <= '0;
`ifdef DCM_TIMEOUT_EN
         tmo_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         m_q     <= m_d;
         pend_q  <= pend_d;
         req_q   <= req_d;
         cur_q   <= cur_d;
`ifdef DCM_TIMEOUT_EN
         tmo_q   <= tmo_d;
         err_q   <= err_d;
`endif
      end
   end
endmodule

// File: doc/dcm_multi_controller.md
Name: dcm_multi_controller

Overview:
Parametrised successor to the single-DCM clock controller. Decodes in-band clock commands carried in malformed work packets (all-zero midstate, timestamp FFFFFFFF) and serially programs up to NUM_DCM DCM_CLKGEN instances through their PROGEN/PROGDATA/PROGDONE ports. Sits between the UART work-packet deserialiser and the hashing-core clock generators. Adds several features:
- multiplier clamping to a legal range;
- per-channel pending queue;
- forced reprogram;
- PROGDONE timeout with error reporting.

Parameters:
- NUM_DCM, 2, number of DCM channels (1..8).
- INIT_MULT, 16, multiplier requested for every channel after reset.
- MIN_MULT, 2, lowest legal M; requests below it are clamped up to it.
- MAX_MULT, 64, highest legal M; requests above it are clamped down to it.
- DIVIDER, 8, fixed D value; transmitted as D-1.
- DONE_TIMEOUT, 1023, clk cycles to wait for PROGDONE before abort (10-bit counter).

Ports:
- clk, input, 1, sole clock; also drives every DCM PROGCLK.
- reset, input, 1, synchronous active-high reset.
- midstate, input, 256, work midstate from the deserialiser.
- data2, input, 256, work data2 from the deserialiser.
- start, input, 1, one-cycle strobe: midstate/data2 valid.
- dcm_prog_en, output, NUM_DCM, PROGEN per channel.
- dcm_prog_data, output, NUM_DCM, PROGDATA per channel.
- dcm_prog_done, input, NUM_DCM, PROGDONE per channel.
- busy, output, 1, high while a programming frame is in flight.
- cur_mult, output, 8*NUM_DCM, last successfully programmed M per channel; channel i occupies [8i+7:8i].
- err, output, 1, sticky: PROGDONE timeout occurred; cleared by command 3 or reset.

Behaviour:
Reset values:
- dcm_prog_en = 0, dcm_prog_data = 0, busy = 0, err = 0.
- cur_mult = 0 on all channels.
- req_mult[i] = clamp(INIT_MULT) for every channel.
- pending = all ones, so every channel programs after reset.

Command decode (same cycle as start):
- Trigger condition: start && data2[63:32]==32'hFFFFFFFF && midstate==0.
- Fields: id = data2[71:64], arg = data2[79:72], chan = data2[87:80], chk = data2[95:88].
- The command is valid only when chk == id^arg^chan^8'hA5. Invalid commands are dropped silently.
- Commands are accepted while busy; they only update request registers.
- id 0: req_mult[chan] <= clamp(arg); pending[chan] set if clamp(arg) != cur_mult[chan]. chan >= NUM_DCM is ignored.
- id 1: all channels get req_mult <= clamp(arg), with the same pending rule as id 0.
- id 2: pending[chan] set unconditionally (forced reprogram).
- id 3: err cleared.
- Any other id: ignored.
- clamp(x) = x<MIN_MULT ? MIN_MULT : x>MAX_MULT ? MAX_MULT : x.

Arbitration:
- When idle and pending != 0, select the lowest-index pending channel.
- Latch frame = {req_mult-1, DIVIDER-1}, clear that channel's pending bit, set busy, enter LOAD_D.
- If the channel's req_mult changes mid-frame, its pending bit is set again and the channel is reprogrammed after the current frame.

Frame FSM (one state per clk; only the selected channel toggles, all others hold en=0, data=0):
- IDLE.
- LOAD_D: en/data = 1/1, then 1/0, then 8 bits of D-1 LSB-first with en=1.
- GAP1: 2 cycles, en=0.
- LOAD_M: en/data = 1/1, 1/1, then 8 bits of M-1 LSB-first with en=1.
- GAP2: 2 cycles, en=0.
- GO: 1 cycle, en=1, data=0.
- WAIT_DONE: en=0; hold until dcm_prog_done[sel] is high.
- On done: cur_mult[sel] <= latched M; busy <= 0; return to IDLE. The next frame may start on the following cycle.
- Frame length from LOAD_D entry to WAIT_DONE entry: 25 cycles.

Timeout:
- In WAIT_DONE, a counter increments each cycle.
- When it reaches DONE_TIMEOUT: err <= 1, cur_mult is left unchanged, the pending bit is NOT set again, return to IDLE.

Reset mid-frame: everything returns to reset values and the complete initial programming pass restarts.

Optional Feature:
DCM_TIMEOUT_EN.
- Defined: timeout counter and err behaviour as above.
- Undefined: the counter is removed, WAIT_DONE waits indefinitely, and err is tied to 0.

Test Plan:
- Reset with NUM_DCM=2: channel 0 then channel 1 each get a frame. Data bits are 0x07 (D-1) then 0x0F (M-1). Model asserts done 5 cycles after GO -> cur_mult=={16,16}, busy=0.
- Command id0, chan1, arg 40, valid chk -> one frame on channel 1 only with M-1 bits 0x27; channel 0 en stays 0; cur_mult[15:8]=40.
- id1 arg 200, then id1 arg 0 -> programmed M=64 (MAX clamp), then M=2 (MIN clamp) on both channels.
- Bad chk, midstate!=0, or timestamp FFFFFFFE -> no frame, busy stays 0. id0 with arg == current M -> no frame; id2 on the same channel -> frame issued.
- With DCM_TIMEOUT_EN, done never asserted -> err=1 exactly DONE_TIMEOUT cycles after WAIT_DONE entry, cur_mult unchanged. id3 -> err=0.
- Assert reset at frame cycle 12 -> en/data=0 next cycle, then a full reset programming pass occurs.
